run_before_encoder: RTL and testbench

//  CAVLC run_before codeword generator, directly downstream of the run-before counter.

---
 rtl/run_before_encoder_pkg.sv | 11 +
 rtl/run_before_encoder_if.sv | 10 +
 rtl/run_before_encoder_vlc_lut.sv | 38 +++
 rtl/run_before_encoder.sv | 88 ++++++++
 tb/tb_run_before_encoder.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/run_before_encoder_pkg.sv
// run_before_encoder_pkg: shared types/constants for the CAVLC run_before encoder (FSM states, codeword struct, run list)
package run_before_encoder_pkg;
  localparam int LIST_DEPTH = 16;
  localparam int RB_MAX_LEN = 11;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} rbenc_state_e;
  typedef struct packed {
    logic [RB_MAX_LEN-1:0] code;
    logic [3:0]            len;
  } rb_vlc_t;
  typedef logic [LIST_DEPTH-1:0][4:0] rb_list_t;
endpackage

// File: rtl/run_before_encoder_if.sv
// run_before_encoder_if: codeword stream (valid/ready, right-aligned code, length); master = encoder, slave = packer
interface run_before_encoder_if;
  import run_before_encoder_pkg::*;
  logic                  rb_valid;
  logic                  rb_ready;
  logic [RB_MAX_LEN-1:0] rb_code;
  logic [3:0]            rb_len;
  modport master (output rb_valid, rb_code, rb_len, input rb_ready);
  modport slave  (input rb_valid, rb_code, rb_len, output rb_ready);
endinterface

// File: rtl/run_before_encoder_vlc_lut.sv
// run_before_vlc_lut: run_before VLC table; in run_i/zl_i, out vlc_o {code,len}, ok_o (0 when run>zerosLeft or zl=0)
module run_before_vlc_lut
  import run_before_encoder_pkg::*;
(
  input  logic [4:0] run_i,
  input  logic [3:0] zl_i,
  output rb_vlc_t    vlc_o,
  output logic       ok_o
);
  logic [3:0] r;
  assign r = run_i[3:0];
  assign ok_o = (zl_i != 4'd0) && (run_i <= {1'b0, zl_i}) && (run_i <= 5'd14);
  always_comb begin
    vlc_o = '0;
    if (zl_i == 4'd1) begin
      vlc_o.code = 11'(r == 4'd0);
      vlc_o.len  = 4'd1;
    end else if (zl_i == 4'd2) begin
      vlc_o.code = 11'(r < 4'd2);
      vlc_o.len  = r == 4'd0 ? 4'd1 : 4'd2;
    end else if (zl_i == 4'd3) begin
      vlc_o.code = 11'(4'd3 - r);
      vlc_o.len  = 4'd2;
    end else if (zl_i == 4'd4) begin
      vlc_o.code = r < 4'd3 ? 11'(4'd3 - r) : 11'(4'd4 - r);
      vlc_o.len  = r < 4'd3 ? 4'd2 : 4'd3;
    end else if (zl_i == 4'd5) begin
      vlc_o.code = r < 4'd2 ? 11'(4'd3 - r) : 11'(4'd5 - r);
      vlc_o.len  = r < 4'd2 ? 4'd2 : 4'd3;
    end else if (zl_i == 4'd6) begin
      vlc_o.code = r == 4'd0 ? 11'd3 : 11'((r - 4'd1) ^ 4'(r > 4'd2));
      vlc_o.len  = r == 4'd0 ? 4'd2 : 4'd3;
    end else begin
      vlc_o.code = r < 4'd7 ? 11'(4'd7 - r) : 11'd1;
      vlc_o.len  = r < 4'd7 ? 4'd3 : r - 4'd3;
    end
  end
endmodule

// File: rtl/run_before_encoder.sv
// run_before_encoder: latches a block's run list, walks it while zerosLeft>0 and streams one run_before codeword per entry; ports clk/rst/h264_reset, start_i/ready_o, total_zeros_i, rb_cnt_i, rb_list_i, rb (codeword stream master), done_o, err_o
module run_before_encoder
  import run_before_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       h264_reset,
  input  logic       start_i,
  output logic       ready_o,
  input  logic [3:0] total_zeros_i,
  input  logic [4:0] rb_cnt_i,
  input  rb_list_t   rb_list_i,
  run_before_encoder_if.master rb,
  output logic       done_o,
  output logic       err_o
);
  rbenc_state_e state_q, state_d;
  rb_list_t     list_q;
  logic [4:0]   cnt_q, idx_q, idx_d, idx_n;
  logic [3:0]   zl_q, zl_d, zl_n;
  rb_vlc_t      vlc_q, vlc_d, lut_vlc;
  logic         err_q, err_d, load, lut_ok;
  logic [4:0]   lut_run;
  logic [3:0]   lut_zl;
  assign ready_o     = state_q == IDLE;
  assign done_o      = state_q == DONE;
  assign err_o       = err_q;
  assign rb.rb_valid = state_q == EMIT;
  assign rb.rb_code  = vlc_q.code;
  assign rb.rb_len   = vlc_q.len;
  // the error check on every entry precedes this subtract, so zl never wraps
  assign idx_n   = idx_q + 5'd1;
  assign zl_n    = zl_q - 4'(list_q[idx_q[3:0]]);
  assign lut_run = state_q == LOAD ? list_q[0] : list_q[idx_n[3:0]];
  assign lut_zl  = state_q == LOAD ? zl_q : zl_n;
  run_before_vlc_lut u_lut (.run_i(lut_run), .zl_i(lut_zl), .vlc_o(lut_vlc), .ok_o(lut_ok));
  always_comb begin
    state_d = state_q;
    vlc_d   = vlc_q;
    zl_d    = zl_q;
    idx_d   = idx_q;
    err_d   = err_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = LOAD;
        zl_d    = total_zeros_i;
        idx_d   = '0;
        err_d   = 1'b0;
        load    = 1'b1;
      end
      LOAD: begin
        state_d = (zl_q == 4'd0 || cnt_q == 5'd0 || !lut_ok) ? DONE : EMIT;
        err_d   = zl_q != 4'd0 && cnt_q != 5'd0 && !lut_ok;
        vlc_d   = lut_vlc;
      end
      EMIT: if (rb.rb_ready) begin
        zl_d    = zl_n;
        idx_d   = idx_n;
        state_d = (idx_n == cnt_q || zl_n == 4'd0 || !lut_ok) ? DONE : EMIT;
        err_d   = idx_n != cnt_q && zl_n != 4'd0 && !lut_ok;
        vlc_d   = lut_vlc;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || h264_reset) begin
      state_q <= IDLE;
      list_q  <= '0;
      cnt_q   <= '0;
      zl_q    <= '0;
      idx_q   <= '0;
      vlc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zl_q    <= zl_d;
      idx_q   <= idx_d;
      vlc_q   <= vlc_d;
      err_q   <= err_d;
      if (load) begin
        list_q <= rb_list_i;
        cnt_q  <= rb_cnt_i;
      end
    end
  end
endmodule

// File: tb/tb_run_before_encoder.sv
// tb_run_before_encoder: directed + random blocks checked against a table-driven model of the run_before codewords
module tb_run_before_encoder;
  import run_before_encoder_pkg::*;
  logic clk = 1'b0, rst = 1'b1, h264_reset = 1'b0, start_i = 1'b0;
  logic ready_o, done_o, err_o;
  logic [3:0] total_zeros_i = '0;
  logic [4:0] rb_cnt_i = '0;
  rb_list_t rb_list_i = '0;
  int n_chk = 0, n_fail = 0;
  int lst[16];
  run_before_encoder_if rb ();
  run_before_encoder dut (.clk(clk), .rst(rst), .h264_reset(h264_reset), .start_i(start_i), .ready_o(ready_o),
    .total_zeros_i(total_zeros_i), .rb_cnt_i(rb_cnt_i), .rb_list_i(rb_list_i), .rb(rb.master),
    .done_o(done_o), .err_o(err_o));
  always #5 clk = ~clk;
  // rows: zerosLeft 1..6, last row zerosLeft>6 (runs 0..6)
  string tab[7][7] = '{
    '{"1", "0", "", "", "", "", ""},
    '{"1", "01", "00", "", "", "", ""},
    '{"11", "10", "01", "00", "", "", ""},
    '{"11", "10", "01", "001", "000", "", ""},
    '{"11", "10", "011", "010", "001", "000", ""},
    '{"11", "000", "001", "011", "010", "101", "100"},
    '{"111", "110", "101", "100", "011", "010", "001"}};
  function automatic string vlc_str(int run, int zl);
    string s = "";
    if (zl <= 6) return tab[zl-1][run];
    if (run < 7) return tab[6][run];
    for (int i = 0; i < run - 4; i++) s = {s, "0"};
    return {s, "1"};
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run_block(input int tz, input int cnt, input int mode, input string tag);
    int ec[$], el[$];
    bit experr = 0, held = 0, seen_done = 0, r;
    int zl = tz, widx = 0, last_hs = 1, stall = 0, hc = 0, hl = 0;
    if (tz != 0) begin
      for (int i = 0; i < cnt; i++) begin
        string s;
        int v = 0;
        if (lst[i] > zl || lst[i] > 14) begin experr = 1; break; end
        s = vlc_str(lst[i], zl);
        for (int k = 0; k < s.len(); k++) v = (v << 1) | int'(s[k] == "1");
        ec.push_back(v);
        el.push_back(s.len());
        zl -= lst[i];
        if (zl == 0) break;
      end
    end
    total_zeros_i = 4'(tz);
    rb_cnt_i = 5'(cnt);
    for (int i = 0; i < 16; i++) rb_list_i[i] = 5'(lst[i]);
    start_i = 1'b1;
    for (int c = 1; c <= 300 && !seen_done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i = 1'b0;
        chk({tag, " ready_busy"}, int'(ready_o), 0);
        chk({tag, " err_cleared"}, int'(err_o), 0);
      end
      if (rb.rb_valid) begin
        if (held) begin
          chk({tag, " stable_code"}, int'(rb.rb_code), hc);
          chk({tag, " stable_len"}, int'(rb.rb_len), hl);
        end else begin
          chk({tag, " word_gap"}, c, last_hs + 1);
          chk({tag, " extra_word"}, int'(widx < ec.size()), 1);
          chk({tag, " code"}, int'(rb.rb_code), widx < ec.size() ? ec[widx] : -1);
          chk({tag, " len"}, int'(rb.rb_len), widx < el.size() ? el[widx] : -1);
        end
        hc = int'(rb.rb_code);
        hl = int'(rb.rb_len);
        r = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : (stall == 3);
        stall = r ? 0 : stall + 1;
        rb.rb_ready = r;
        held = !r;
        if (r) begin widx++; last_hs = c; end
      end else begin
        rb.rb_ready = 1'($urandom % 2);
        held = 0;
      end
      if (done_o) begin
        seen_done = 1;
        chk({tag, " word_count"}, widx, ec.size());
        chk({tag, " done_time"}, c, last_hs + 1);
        chk({tag, " err"}, int'(err_o), int'(experr));
        @(negedge clk);
        chk({tag, " done_pulse"}, int'(done_o), 0);
        chk({tag, " ready_idle"}, int'(ready_o), 1);
        chk({tag, " err_sticky"}, int'(err_o), int'(experr));
      end
    end
    if (!seen_done) chk({tag, " timeout"}, 0, 1);
  endtask
  task automatic set3(input int a, input int b, input int c);
    lst = '{default: 0};
    lst[0] = a;
    lst[1] = b;
    lst[2] = c;
  endtask
  initial begin
    rb.rb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ready", int'(ready_o), 1);
    chk("rst valid", int'(rb.rb_valid), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst err", int'(err_o), 0);
    chk("rst code", int'(rb.rb_code), 0);
    chk("rst len", int'(rb.rb_len), 0);
    rst = 1'b0;
    @(negedge clk);
    set3(1, 0, 2); run_block(3, 3, 0, "tz3");
    set3(7, 3, 0); run_block(10, 2, 0, "tz10");
    set3(1, 1, 1); run_block(0, 5, 0, "tz0");
    set3(1, 1, 1); run_block(4, 0, 0, "cnt0");
    set3(1, 3, 0); run_block(4, 3, 2, "stall");
    set3(2, 0, 0); run_block(1, 1, 0, "err");
    set3(0, 1, 0); run_block(2, 2, 1, "after_err");
    set3(15, 0, 0); run_block(15, 1, 0, "r15");
    set3(1, 0, 2);
    total_zeros_i = 4'd3;
    rb_cnt_i = 5'd3;
    for (int i = 0; i < 16; i++) rb_list_i[i] = 5'(lst[i]);
    start_i = 1'b1;
    rb.rb_ready = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("hrst pre_valid", int'(rb.rb_valid), 1);
    h264_reset = 1'b1;
    @(negedge clk);
    h264_reset = 1'b0;
    chk("hrst valid", int'(rb.rb_valid), 0);
    chk("hrst ready", int'(ready_o), 1);
    chk("hrst done", int'(done_o), 0);
    @(negedge clk);
    chk("hrst no_done", int'(done_o), 0);
    for (int t = 0; t < 60; t++) begin
      int tz = int'($urandom_range(0, 15));
      int cnt = int'($urandom_range(0, 15));
      int rem = tz;
      lst = '{default: 0};
      for (int i = 0; i < 16; i++) begin
        lst[i] = ($urandom % 10 == 0) ? int'($urandom_range(rem + 1, 16)) : int'($urandom_range(0, rem));
        if (lst[i] <= rem) rem -= lst[i];
      end
      run_block(tz, cnt, 1, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
